lcd_cmd_feeder: RTL and testbench

LCD_CMD_FEEDER -- requirements
Module: lcd_cmd_feeder

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_cmd_feeder_if.sv | 28 ++
 rtl/lcd_cmd_fifo.sv | 50 +++++
 rtl/lcd_cmd_feeder.sv | 103 ++++++++++
 tb/tb_lcd_cmd_feeder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command feeder: command codes, image geometry
// and the feeder state encoding.
package lcd_pkg;

    localparam int IMG_BYTES  = 108;
    localparam int IMG_ADDR_W = 7;

    typedef enum logic [2:0] {
        CMD_LOAD_DATA   = 3'd0,
        CMD_ZOOM_IN     = 3'd1,
        CMD_ZOOM_FIT    = 3'd2,
        CMD_SHIFT_RIGHT = 3'd3,
        CMD_SHIFT_LEFT  = 3'd4,
        CMD_SHIFT_UP    = 3'd5,
        CMD_SHIFT_DOWN  = 3'd6,
        CMD_REFLASH     = 3'd7
    } lcd_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD,
        ST_WAIT
    } feeder_state_e;

    // Only LOAD_DATA streams image bytes after it is issued.
    function automatic logic is_stream_cmd(input logic [2:0] c);
        return c == CMD_LOAD_DATA;
    endfunction

endpackage

// File: rtl/lcd_cmd_feeder_if.sv
// Bundles the host handshake, image memory port and LCD controller port.
// The feeder uses the slave view; the host/environment uses the master view.
interface lcd_cmd_feeder_if;
    import lcd_pkg::*;

    logic [2:0]            host_cmd;
    logic                  host_valid;
    logic                  host_ready;
    logic                  img_rd;
    logic [IMG_ADDR_W-1:0] img_addr;
    logic [7:0]            img_data;
    logic [2:0]            cmd;
    logic                  cmd_valid;
    logic [7:0]            datain;
    logic                  busy;
    logic                  idle;

    modport slave (
        input  host_cmd, host_valid, img_data, busy,
        output host_ready, img_rd, img_addr, cmd, cmd_valid, datain, idle
    );

    modport master (
        output host_cmd, host_valid, img_data, busy,
        input  host_ready, img_rd, img_addr, cmd, cmd_valid, datain, idle
    );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Small command queue with registered head; DEPTH must be a power of two so the
// pointers wrap naturally.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/lcd_cmd_feeder.sv
// Pulls host commands from a queue and issues them to the LCD controller one at
// a time, streaming the image out of memory for LOAD_DATA.
module lcd_cmd_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int IMG_BYTES  = lcd_pkg::IMG_BYTES
) (
    input logic             clk,
    input logic             reset,
    lcd_cmd_feeder_if.slave bus
);
    import lcd_pkg::IMG_ADDR_W, lcd_pkg::CMD_REFLASH, lcd_pkg::is_stream_cmd;
    import lcd_pkg::feeder_state_e, lcd_pkg::ST_IDLE, lcd_pkg::ST_ISSUE;
    import lcd_pkg::ST_LOAD, lcd_pkg::ST_WAIT;

    localparam logic [IMG_ADDR_W-1:0] LAST_ADDR = IMG_ADDR_W'(IMG_BYTES - 1);

    feeder_state_e         r_state;
    feeder_state_e         w_next_state;
    logic [2:0]            r_cmd;
    logic [IMG_ADDR_W-1:0] r_addr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [2:0]            w_head;
    logic                  w_cmd_valid;
    logic                  w_img_rd;
    logic [IMG_ADDR_W-1:0] w_img_addr;

    assign w_push = bus.host_valid && !w_full;
    assign w_pop  = (r_state == ST_IDLE) && !w_empty && !bus.busy;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.host_cmd),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // The popped command is latched on the pop edge so it is stable during ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_REFLASH;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) r_cmd <= w_head;
            if (r_state == ST_ISSUE)
                r_addr <= IMG_ADDR_W'(1);
            else if (r_state == ST_LOAD)
                r_addr <= r_addr + 1'b1;
            else
                r_addr <= '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd_valid  = 1'b0;
        w_img_rd     = 1'b0;
        w_img_addr   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_cmd_valid = 1'b1;
                if (is_stream_cmd(r_cmd)) begin
                    w_img_rd     = 1'b1;
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_LOAD: begin
                w_img_rd   = 1'b1;
                w_img_addr = r_addr;
                if (r_addr == LAST_ADDR) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.busy) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign bus.cmd_valid  = w_cmd_valid;
    assign bus.img_rd     = w_img_rd;
    assign bus.img_addr   = w_img_addr;
    assign bus.cmd        = r_cmd;
    assign bus.datain     = bus.img_data;
    assign bus.host_ready = !w_full;
    assign bus.idle       = (r_state == ST_IDLE) && w_empty;

endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// Randomised bench for lcd_cmd_feeder: a timing-level reference model predicts
// every output each cycle, with behavioural image memory and LCD controller.
module tb_lcd_cmd_feeder;
    import lcd_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    lcd_cmd_feeder_if busIf();

    lcd_cmd_feeder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .IMG_BYTES  (IMG_BYTES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] image [IMG_BYTES];
    logic [7:0] frame [IMG_BYTES];

    // Reference model: the feeder is free or busy until a known cycle, and
    // the queue is a plain SV queue of pending commands.
    int         curCycle = 0;
    bit         modelValid = 0;
    logic [2:0] modelQ[$];
    bit         modelFree = 1;
    int         issueCycle = -1000;
    bit         issueLoad = 0;
    int         waitStart = 0;
    logic [2:0] lastCmd = CMD_REFLASH;
    bit         lastAccepted = 0;
    bit         prevExpRd = 0;
    int         prevExpAddr = 0;
    int         dutPulses = 0;

    int  busyRemain = 0;
    int  busyLen = 5;
    bit  randomBusy = 0;
    bit  busyForce = 0;

    bit         sCmdValid;
    logic [2:0] sCmd;
    bit         sRd;
    logic [6:0] sAddr;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     tag, observed, expected, curCycle);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [2:0] c);
        busIf.host_valid = valid;
        busIf.host_cmd   = c;
        busIf.busy       = (busyRemain > 0) || busyForce;
    endtask

    task automatic runCycle();
        bit expRd;
        int expAddr;
        bit issueNext;
        bit accept;
        @(negedge clk);
        if (modelValid) begin
            expRd   = issueLoad && curCycle >= issueCycle && curCycle < issueCycle + IMG_BYTES;
            expAddr = expRd ? curCycle - issueCycle : 0;
            checkOutput("cmd_valid", busIf.cmd_valid, curCycle == issueCycle);
            checkOutput("cmd", busIf.cmd, lastCmd);
            checkOutput("img_rd", busIf.img_rd, expRd);
            checkOutput("img_addr", busIf.img_addr, expAddr);
            checkOutput("host_ready", busIf.host_ready, modelQ.size() < FIFO_DEPTH);
            checkOutput("idle", busIf.idle, modelFree && modelQ.size() == 0);
            if (prevExpRd) begin
                checkOutput("datain", busIf.datain, image[prevExpAddr]);
                frame[prevExpAddr] = busIf.datain;
            end
            prevExpRd   = expRd;
            prevExpAddr = expAddr;
        end
        sCmdValid = busIf.cmd_valid;
        sCmd      = busIf.cmd;
        sRd       = busIf.img_rd;
        sAddr     = busIf.img_addr;
        if (sCmdValid) dutPulses++;

        lastAccepted = 0;
        if (reset) begin
            modelValid = 1;
            modelQ.delete();
            modelFree  = 1;
            issueCycle = -1000;
            issueLoad  = 0;
            lastCmd    = CMD_REFLASH;
        end else if (modelValid) begin
            accept    = busIf.host_valid && modelQ.size() < FIFO_DEPTH;
            issueNext = modelFree && modelQ.size() > 0 && !busIf.busy;
            if (issueNext) begin
                lastCmd    = modelQ.pop_front();
                issueCycle = curCycle + 1;
                issueLoad  = (lastCmd == CMD_LOAD_DATA);
                waitStart  = issueCycle + (issueLoad ? IMG_BYTES : 1);
                modelFree  = 0;
            end else if (!modelFree && curCycle >= waitStart && !busIf.busy) begin
                modelFree = 1;
            end
            if (accept) modelQ.push_back(busIf.host_cmd);
            lastAccepted = accept;
        end

        @(posedge clk);
        curCycle++;
        #1;
        busIf.img_data = sRd ? image[sAddr] : 8'($urandom);
        if (reset)
            busyRemain = 0;
        else if (sCmdValid)
            busyRemain = (sCmd == CMD_LOAD_DATA) ? IMG_BYTES + 2 :
                         (randomBusy ? int'($urandom_range(1, 20)) : busyLen);
        else if (busyRemain > 0)
            busyRemain--;
        busIf.busy = (busyRemain > 0) || busyForce;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(modelFree && modelQ.size() == 0) && n < budget) begin
            runCycle();
            n++;
        end
        runCycle();
        runCycle();
        checkOutput("drainDone", 32'(modelFree && modelQ.size() == 0), 1);
    endtask

    task automatic pushCmd(input logic [2:0] c);
        int n = 0;
        applyStimulus(1, c);
        do begin
            runCycle();
            n++;
        end while (!lastAccepted && n < 500);
        checkOutput("pushAccepted", 32'(lastAccepted), 1);
        applyStimulus(0, 3'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0] seqCmds [5];
        int n;
        int badBytes;
        logic [2:0] c;

        for (int i = 0; i < IMG_BYTES; i++) image[i] = 8'($urandom);
        busIf.img_data = 8'h00;
        applyStimulus(0, 3'd0);

        reset = 1'b1;
        repeat (3) runCycle();
        reset = 1'b0;
        runCycle();

        // Single LOAD_DATA with full image stream.
        pushCmd(CMD_LOAD_DATA);
        drain(400);

        // Two short commands separated by a long controller busy window.
        busyLen = 20;
        pushCmd(CMD_SHIFT_RIGHT);
        pushCmd(CMD_REFLASH);
        drain(400);

        // Fill the queue while the controller is held busy externally.
        busyLen = 3;
        busyForce = 1'b1;
        seqCmds = '{CMD_ZOOM_IN, CMD_SHIFT_LEFT, CMD_SHIFT_DOWN, CMD_ZOOM_FIT, CMD_SHIFT_UP};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, seqCmds[i]);
            n = 0;
            do begin
                if (i == 4 && n == 6) begin
                    busyForce = 1'b0;
                    applyStimulus(1, seqCmds[i]);
                end
                runCycle();
                n++;
            end while (!lastAccepted && n < 200);
            checkOutput("fullPush", 32'(lastAccepted), 1);
        end
        applyStimulus(0, 3'd0);
        drain(600);

        // Reset in the middle of an image stream, with commands queued behind it.
        pushCmd(CMD_LOAD_DATA);
        pushCmd(CMD_ZOOM_IN);
        pushCmd(CMD_SHIFT_UP);
        n = 0;
        while (curCycle != issueCycle + 50 && n < 400) begin
            runCycle();
            n++;
        end
        checkOutput("reachAddr50", busIf.img_addr, 50);
        reset = 1'b1;
        runCycle();
        reset = 1'b0;
        runCycle();
        runCycle();
        drain(400);

        // Full command sequence against the controller model.
        randomBusy = 1'b1;
        for (int i = 0; i < IMG_BYTES; i++) frame[i] = 8'h00;
        dutPulses = 0;
        pushCmd(CMD_LOAD_DATA);
        pushCmd(CMD_ZOOM_IN);
        pushCmd(CMD_SHIFT_UP);
        pushCmd(CMD_ZOOM_FIT);
        drain(1000);
        checkOutput("seqPulses", dutPulses, 4);
        badBytes = 0;
        for (int i = 0; i < IMG_BYTES; i++) if (frame[i] !== image[i]) badBytes++;
        checkOutput("frameBytes", badBytes, 0);

        // Random traffic with occasional external busy windows.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) busyForce = !busyForce;
            if ($urandom_range(0, 7) == 0)
                c = CMD_LOAD_DATA;
            else
                c = 3'($urandom_range(1, 7));
            applyStimulus($urandom_range(0, 2) == 0, c);
            runCycle();
        end
        busyForce = 1'b0;
        applyStimulus(0, 3'd0);
        drain(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
